// File: rtl/fcmp_wb_queue.sv
// FP-compare writeback queue: stores flags/result/tag plus branch and invalid outcomes evaluated at enqueue.
// One-cycle push-to-head latency, no bypass; in_rdy depends only on occupancy, so a full queue refuses pushes even while popping.
module fcmp_wb_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [5:0]                 in_flags,
  input  logic [67:0]                in_res,
  input  logic                       in_res_en,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [4:0]                 in_jumpType,
  input  logic                       in_invExcpt,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [5:0]                 out_flags,
  output logic [67:0]                out_res,
  output logic                       out_res_en,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_jtaken,
  output logic                       out_excpt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sticky_inv,
  input  logic                       clr_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [5:0]       flags;
    logic [67:0]      res;
    logic             res_en;
    logic [TAG_W-1:0] tag;
    logic             jtaken;
    logic             excpt;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sticky_q, sticky_d;

  logic            push, pop;
  entry_t          new_entry;
  entry_t          head;

  // Flag word layout is {C,0,0,S,Z,U}.
  function automatic logic jt_eval(input logic [5:0] f, input logic [4:0] jt);
    logic c, s, z, u;
    c = f[5];
    s = f[2];
    z = f[1];
    u = f[0];
    case (jt)
      5'd0:    jt_eval = 1'b0;
      5'd1:    jt_eval = 1'b1;
      5'd2:    jt_eval = z;
      5'd3:    jt_eval = ~z;
      5'd4:    jt_eval = c;
      5'd5:    jt_eval = ~c;
      5'd6:    jt_eval = c | z;
      5'd7:    jt_eval = ~c & ~z;
      5'd8:    jt_eval = u;
      5'd9:    jt_eval = ~u;
      5'd10:   jt_eval = s;
      5'd11:   jt_eval = ~s;
      default: jt_eval = 1'b0;
    endcase
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign in_rdy  = (count_q < CW'(DEPTH));
  assign out_vld = (count_q != '0);

  assign out_flags  = head.flags;
  assign out_res    = head.res;
  assign out_res_en = head.res_en;
  assign out_tag    = head.tag;
  assign out_jtaken = head.jtaken;
  assign out_excpt  = head.excpt;
  assign count      = count_q;
  assign sticky_inv = sticky_q;

  always_comb begin
    push = in_vld & in_rdy & ~flush;
    pop  = out_vld & out_rdy & ~flush;

    new_entry.flags  = in_flags;
    new_entry.res    = in_res;
    new_entry.res_en = in_res_en;
    new_entry.tag    = in_tag;
    new_entry.jtaken = jt_eval(in_flags, in_jumpType);
    new_entry.excpt  = in_flags[0] & in_invExcpt;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end

    // A clear in the same cycle as an excepting pop loses to the set.
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (pop && head.excpt) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fcmp_wb_queue.sv
// Bench for fcmp_wb_queue: directed sequences, a jumpType vector table, and a random run against a queue model.
module tb_fcmp_wb_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 9;

  logic             clk, rst, flush, in_vld, in_rdy;
  logic [5:0]       in_flags;
  logic [67:0]      in_res;
  logic             in_res_en;
  logic [TAG_W-1:0] in_tag;
  logic [4:0]       in_jumpType;
  logic             in_invExcpt;
  logic             out_vld, out_rdy;
  logic [5:0]       out_flags;
  logic [67:0]      out_res;
  logic             out_res_en;
  logic [TAG_W-1:0] out_tag;
  logic             out_jtaken, out_excpt;
  logic [2:0]       count;
  logic             sticky_inv, clr_sticky;

  fcmp_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_flags(in_flags), .in_res(in_res),
    .in_res_en(in_res_en), .in_tag(in_tag), .in_jumpType(in_jumpType),
    .in_invExcpt(in_invExcpt),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_flags(out_flags), .out_res(out_res),
    .out_res_en(out_res_en), .out_tag(out_tag), .out_jtaken(out_jtaken),
    .out_excpt(out_excpt), .count(count), .sticky_inv(sticky_inv),
    .clr_sticky(clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]       flags;
    logic [67:0]      res;
    logic             res_en;
    logic [TAG_W-1:0] tag;
    logic             jt;
    logic             ex;
  } mentry_t;

  typedef struct {
    logic [5:0] flags;
    logic [4:0] jt;
    logic       inv;
    logic       exp_jt;
    logic       exp_ex;
  } vec_t;

  mentry_t mq[$];
  logic    m_sticky;
  vec_t    vt[64];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_vld = 0; in_flags = 0; in_res = 0; in_res_en = 0; in_tag = 0;
    in_jumpType = 0; in_invExcpt = 0; out_rdy = 0; flush = 0; clr_sticky = 0;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] jt, input logic [TAG_W-1:0] tg,
                       input logic inv);
    in_vld = 1; in_flags = f; in_jumpType = jt; in_tag = tg; in_invExcpt = inv;
    in_res = {$urandom, $urandom, $urandom}; in_res_en = 1'($urandom);
  endtask

  // Branch outcome from the condition table, indexed by jumpType.
  function automatic logic ref_jt(input logic [5:0] f, input logic [4:0] jt);
    logic c, s, z, u;
    logic [11:0] v;
    c = f[5]; s = f[2]; z = f[1]; u = f[0];
    v = {~s, s, ~u, u, ~c & ~z, c | z, ~c, c, ~z, z, 1'b1, 1'b0};
    if (jt >= 5'd12) return 1'b0;
    return v[jt[3:0]];
  endfunction

  initial begin
    logic [11:0] zmask, umask;
    logic [67:0] saved_res;
    mentry_t     e, h;
    logic        rdy_m, push_m, pop_m;

    idle();
    rst = 0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_sticky", sticky_inv, 0);
    chk("rst_out_data", {out_flags, out_res, out_res_en, out_tag, out_jtaken, out_excpt}, 0);
    rst = 1;
    tick();

    // Single push, head held
    drive(6'b100000, 5'd4, 9'h05, 0);
    saved_res = in_res;
    tick();
    in_vld = 0;
    chk("t1_out_vld", out_vld, 1);
    chk("t1_jtaken", out_jtaken, 1);
    chk("t1_tag", out_tag, 9'h05);
    chk("t1_count", count, 1);
    chk("t1_res", out_res, saved_res);
    out_rdy = 1;
    tick();
    out_rdy = 0;
    chk("t1_drain", count, 0);

    // Invalid exception and sticky flag
    drive(6'b100001, 5'd0, 9'h07, 1);
    tick();
    in_vld = 0;
    chk("t2_excpt", out_excpt, 1);
    chk("t2_sticky_before", sticky_inv, 0);
    out_rdy = 1;
    tick();
    out_rdy = 0;
    chk("t2_sticky_set", sticky_inv, 1);
    clr_sticky = 1;
    tick();
    clr_sticky = 0;
    chk("t2_sticky_clr", sticky_inv, 0);
    drive(6'b000001, 5'd0, 9'h08, 1);
    tick();
    in_vld = 0;
    out_rdy = 1; clr_sticky = 1;
    tick();
    out_rdy = 0; clr_sticky = 0;
    chk("t2_set_wins", sticky_inv, 1);
    clr_sticky = 1;
    tick();
    clr_sticky = 0;

    // Fill to full, then pop while pushing
    for (int i = 0; i < 5; i++) begin
      drive(6'b000010, 5'd2, TAG_W'(9'h10 + i), 0);
      tick();
      chk("t3_count", count, (i < 4) ? i + 1 : 4);
      chk("t3_in_rdy", in_rdy, (i < 3) ? 1 : 0);
    end
    drive(6'b000010, 5'd2, 9'h1F, 0);
    out_rdy = 1;
    tick();
    in_vld = 0;
    chk("t3_full_pop_count", count, 3);
    for (int i = 1; i < 4; i++) begin
      chk("t3_drain_tag", out_tag, 9'h10 + i);
      tick();
    end
    out_rdy = 0;
    chk("t3_empty", count, 0);

    // Streaming tags 0..9
    out_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      drive(6'b000000, 5'd1, TAG_W'(i), 0);
      tick();
      chk("t4_tag", out_tag, i);
      chk("t4_count", count, 1);
    end
    in_vld = 0;
    tick();
    chk("t4_empty", count, 0);

    // jumpType table, streamed through the queue
    zmask = 12'b1010_0110_0110;
    umask = 12'b1001_1010_1010;
    for (int j = 0; j < 32; j++) begin
      vt[j].flags  = 6'b000010;
      vt[j].jt     = 5'(j);
      vt[j].inv    = 1'b1;
      vt[j].exp_jt = (j < 12) ? zmask[j] : 1'b0;
      vt[j].exp_ex = 1'b0;
      vt[32+j].flags  = 6'b000001;
      vt[32+j].jt     = 5'(j);
      vt[32+j].inv    = 1'(j);
      vt[32+j].exp_jt = (j < 12) ? umask[j] : 1'b0;
      vt[32+j].exp_ex = 1'(j);
    end
    out_rdy = 1;
    for (int i = 0; i < 64; i++) begin
      drive(vt[i].flags, vt[i].jt, TAG_W'(i), vt[i].inv);
      tick();
      chk($sformatf("vec%0d_jt", i), out_jtaken, vt[i].exp_jt);
      chk($sformatf("vec%0d_ex", i), out_excpt, vt[i].exp_ex);
    end
    in_vld = 0;
    tick();
    out_rdy = 0;
    chk("vec_sticky", sticky_inv, 1);
    clr_sticky = 1;
    tick();
    clr_sticky = 0;

    // Async reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(6'b000001, 5'd8, TAG_W'(i), 0);
      tick();
    end
    in_vld = 0;
    chk("t6_count3", count, 3);
    #2 rst = 0;
    #1;
    chk("t6_async_vld", out_vld, 0);
    chk("t6_async_count", count, 0);
    #1 rst = 1;
    tick();

    // Flush with two entries and a push in flight; sticky must survive
    drive(6'b000001, 5'd0, 9'h33, 1);
    tick();
    in_vld = 0; out_rdy = 1;
    tick();
    out_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      drive(6'b000000, 5'd1, TAG_W'(9'h40 + i), 0);
      tick();
    end
    chk("t7_count2", count, 2);
    drive(6'b000000, 5'd1, 9'h50, 0);
    flush = 1;
    tick();
    flush = 0; in_vld = 0;
    chk("t7_flush_count", count, 0);
    chk("t7_flush_vld", out_vld, 0);
    chk("t7_flush_sticky", sticky_inv, 1);
    tick();
    chk("t7_dropped", count, 0);
    clr_sticky = 1;
    tick();
    clr_sticky = 0;

    // Random traffic against the queue model
    mq.delete();
    m_sticky = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc < 1500) begin
        in_vld  = ($urandom_range(0, 3) != 0);
        out_rdy = ($urandom_range(0, 2) == 0);
      end else begin
        in_vld  = ($urandom_range(0, 2) == 0);
        out_rdy = ($urandom_range(0, 3) != 0);
      end
      flush      = ($urandom_range(0, 40) == 0);
      clr_sticky = ($urandom_range(0, 12) == 0);
      in_flags    = 6'($urandom);
      in_jumpType = 5'($urandom);
      in_tag      = TAG_W'($urandom);
      in_invExcpt = 1'($urandom);
      in_res_en   = 1'($urandom);
      in_res      = {$urandom, $urandom, $urandom};
      e.flags = in_flags; e.res = in_res; e.res_en = in_res_en; e.tag = in_tag;
      e.jt = ref_jt(in_flags, in_jumpType);
      e.ex = in_flags[0] & in_invExcpt;

      rdy_m = (mq.size() < DEPTH);
      chk("rnd_in_rdy", in_rdy, rdy_m);
      chk("rnd_out_vld", out_vld, mq.size() != 0);
      if (mq.size() != 0) begin
        h = mq[0];
        chk("rnd_head", {out_flags, out_res, out_res_en, out_tag, out_jtaken, out_excpt},
            {h.flags, h.res, h.res_en, h.tag, h.jt, h.ex});
      end

      push_m = in_vld && rdy_m && !flush;
      pop_m  = (mq.size() != 0) && out_rdy && !flush;
      if (clr_sticky) m_sticky = 0;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop_m) begin
          if (mq[0].ex) m_sticky = 1;
          void'(mq.pop_front());
        end
        if (push_m) mq.push_back(e);
      end

      tick();
      chk("rnd_count", count, mq.size());
      chk("rnd_sticky", sticky_inv, m_sticky);
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
